// File: rtl/div_ctrl.sv
// Sequencer for the shared iterative divider used by DIV/DIVU in EX, one restoring step per cycle.
// Latency: start to ready is DATA_W+1 cycles, or 2 cycles when dividing by zero.
// Backpressure: stallreq_for_div holds IF..EX while busy; start is held until the ready pulse.
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  annul,
    output logic                  stallreq_for_div,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

    state_t               state;
    state_t               state_nxt;
    logic [5:0]           cnt;
    logic [2*DATA_W:0]    dr;
    logic [DATA_W-1:0]    divisor;
    logic [DATA_W-1:0]    dividend_raw;
    logic                 q_neg;
    logic                 r_neg;

    logic                 accept;
    logic                 op1_neg;
    logic                 op2_neg;
    logic [DATA_W-1:0]    abs1;
    logic [DATA_W-1:0]    abs2;
    logic [2*DATA_W:0]    shifted;
    logic [DATA_W:0]      trial;
    logic [2*DATA_W:0]    step;
    logic [DATA_W-1:0]    q_mag;
    logic [DATA_W-1:0]    r_mag;
    logic [DATA_W-1:0]    q_fin;
    logic [DATA_W-1:0]    r_fin;
    logic                 load_end;

    assign accept  = start & ~annul;
    assign op1_neg = signed_div & opdata1[DATA_W-1];
    assign op2_neg = signed_div & opdata2[DATA_W-1];
    assign abs1    = op1_neg ? -opdata1 : opdata1;
    assign abs2    = op2_neg ? -opdata2 : opdata2;

    // Register layout is {partial remainder, dividend bits not yet consumed / quotient bits}.
    assign shifted = dr << 1;
    assign trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
    assign step    = trial[DATA_W] ? {shifted[2*DATA_W:1], 1'b0}
                                   : {trial, shifted[DATA_W-1:1], 1'b1};

    assign q_mag   = step[DATA_W-1:0];
    assign r_mag   = step[2*DATA_W-1:DATA_W];
    assign q_fin   = q_neg ? -q_mag : q_mag;
    assign r_fin   = r_neg ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        stallreq_for_div = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stallreq_for_div = 1'b1;
                    state_nxt        = (opdata2 == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                stallreq_for_div = 1'b1;
                state_nxt        = annul ? S_IDLE : S_END;
            end
            S_ON: begin
                stallreq_for_div = 1'b1;
                if (annul) begin
                    state_nxt = S_IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = S_END;
                end
            end
            S_END: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ready and result are loaded on the edge into END, so both are valid during the END cycle.
    assign load_end = (state_nxt == S_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dr           <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            ready        <= 1'b0;
            result       <= '0;
        end else begin
            ready <= load_end;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dr           <= {{(DATA_W+1){1'b0}}, abs1};
                        divisor      <= abs2;
                        dividend_raw <= opdata1;
                        q_neg        <= op1_neg ^ op2_neg;
                        r_neg        <= op1_neg;
                        cnt          <= '0;
                    end
                end
                S_ON: begin
                    dr  <= step;
                    cnt <= cnt + 6'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
            if (load_end) begin
                // Divide-by-zero returns the dividend untouched, without sign correction.
                if (state == S_DIVZERO) begin
                    result <= {dividend_raw, {DATA_W{1'b1}}};
                end else begin
                    result <= {r_fin, q_fin};
                end
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed vector table, multi-cycle corner sequences, random ops vs. arithmetic model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stallreq_for_div;
    logic        ready;
    logic [63:0] result;

    int n_vec = 0;
    int n_err = 0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .signed_div       (signed_div),
        .opdata1          (opdata1),
        .opdata2          (opdata2),
        .annul            (annul),
        .stallreq_for_div (stallreq_for_div),
        .ready            (ready),
        .result           (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sd;
        bit [31:0]   a;
        bit [31:0]   b;
        bit [63:0]   exp_res;
        int          exp_lat;
        int          exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Quotient truncates toward zero, remainder takes the dividend's sign; /0 gives all-ones r=dividend.
    function automatic logic [63:0] model(input bit sd, input bit [31:0] a, input bit [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sd) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Presents a request at cycle 0 and watches until ready; lat = -1 if it never comes.
    task automatic run_div(input bit sd, input bit [31:0] a, input bit [31:0] b, input bit keep,
                           output logic [63:0] res, output int lat, output int stalls);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        lat        = -1;
        stalls     = 0;
        res        = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stallreq_for_div) stalls++;
            if (ready) begin
                lat = c;
                res = result;
                break;
            end
            @(negedge clk);
        end
        if (!keep) start = 1'b0;
    endtask

    vec_t        vt[10];
    logic [63:0] res;
    logic [63:0] prev;
    int          lat;
    int          stalls;
    bit          sd;
    bit [31:0]   a;
    bit [31:0]   b;

    initial begin
        vt[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 33};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 33};
        vt[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33, 33};
        vt[3] = '{1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},          2,  2};
        vt[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          33, 33};
        vt[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF},  2,  2};
        vt[6] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'd2},          33, 33};
        vt[7] = '{1'b0, 32'd3,          32'd7,          {32'd3, 32'd0},                  33, 33};
        vt[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          33, 33};
        vt[9] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  {32'h7FFF_FFFF, 32'd0},          33, 33};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0; annul = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_stall",  64'(stallreq_for_div), 64'd0);
        chk("reset_ready",  64'(ready),            64'd0);
        chk("reset_result", result,                64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_div(vt[i].sd, vt[i].a, vt[i].b, 1'b0, res, lat, stalls);
            chk($sformatf("vec%0d_result", i), res,          vt[i].exp_res);
            chk($sformatf("vec%0d_latency", i), 64'(lat),    64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_stalls", i), 64'(stalls),  64'(vt[i].exp_stall));
        end

        // Back-to-back with start held across the END cycle.
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, res, lat, stalls);
        chk("b2b_first_result",  res,      {32'hF, 32'h0FFF_FFFF});
        chk("b2b_first_latency", 64'(lat), 64'd33);
        run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, stalls);
        chk("b2b_second_result",  res,      {32'd0, 32'd3});
        chk("b2b_second_latency", 64'(lat), 64'd33);
        prev = res;

        // Annul in the middle of ON: back to IDLE, no ready, result untouched.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd6;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul_stall",  64'(stallreq_for_div), 64'd0);
        chk("annul_ready",  64'(ready),            64'd0);
        chk("annul_result", result,                prev);
        run_div(1'b0, 32'd1000, 32'd3, 1'b0, res, lat, stalls);
        chk("after_annul_result",  res,      {32'd1, 32'd333});
        chk("after_annul_latency", 64'(lat), 64'd33);

        // start and annul together in IDLE are ignored.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2;
        #1;
        chk("start_annul_stall", 64'(stallreq_for_div), 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        chk("start_annul_idle", 64'(stallreq_for_div), 64'd0);

        // Reset in the middle of ON.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        chk("midreset_stall",  64'(stallreq_for_div), 64'd0);
        chk("midreset_ready",  64'(ready),            64'd0);
        chk("midreset_result", result,                64'd0);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready) chk("midreset_no_ready", 64'(ready), 64'd0);
        end

        for (int i = 0; i < 200; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            run_div(sd, a, b, 1'b0, res, lat, stalls);
            chk($sformatf("rand%0d_result sd=%0d a=%h b=%h", i, sd, a, b), res, model(sd, a, b));
            chk($sformatf("rand%0d_latency", i), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
